apu_noise: RTL

APU_NOISE -- requirements
Module: apu_noise

---
 rtl/apu_noise.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/apu_noise.sv
// ---------------------------------------------------------------------------
// apu_noise : 2A03-style noise channel.
//
// A 12-bit period timer paced by cpu_en clocks a 15-bit LFSR. A length
// counter (clocked by hframe) gates the channel, and an envelope unit
// (clocked by qframe) supplies a decaying volume unless constant volume is
// selected. The 4-bit sample is registered one cycle after the state that
// produces it.
//
// Parameters
//   PAL       0 = NTSC period table, 1 = PAL period table
//
// Ports
//   clk       system clock, all state updates on its rising edge
//   reset     synchronous, active-high reset
//   cpu_en    one-cycle strobe, once per CPU cycle
//   qframe    quarter-frame strobe (clocks the envelope)
//   hframe    half-frame strobe (clocks the length counter)
//   reg_we    register write strobe, one cycle
//   reg_addr  register select, 0..3 = $400C..$400F
//   reg_data  write data
//   enable    channel enable ($4015 bit 3)
//   out       noise sample to the mixer
//   active    high while the length counter is nonzero
// ---------------------------------------------------------------------------
module apu_noise #(
  parameter bit PAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       qframe,
  input  logic       hframe,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_data,
  input  logic       enable,
  output logic [3:0] out,
  output logic       active
);

  // -------------------------------------------------------------------------
  // Lookup tables
  // -------------------------------------------------------------------------

  // Timer period in CPU cycles for each period index.
  function automatic logic [11:0] period_cycles(input logic [3:0] idx);
    logic [11:0] cycles;
    // NOTE: a default on every case keeps the lookup purely combinational;
    // a missing arm would otherwise infer a latch.
    if (PAL) begin
      case (idx)
        4'd0:    cycles = 12'd4;
        4'd1:    cycles = 12'd8;
        4'd2:    cycles = 12'd14;
        4'd3:    cycles = 12'd30;
        4'd4:    cycles = 12'd60;
        4'd5:    cycles = 12'd88;
        4'd6:    cycles = 12'd118;
        4'd7:    cycles = 12'd148;
        4'd8:    cycles = 12'd188;
        4'd9:    cycles = 12'd236;
        4'd10:   cycles = 12'd354;
        4'd11:   cycles = 12'd472;
        4'd12:   cycles = 12'd708;
        4'd13:   cycles = 12'd944;
        4'd14:   cycles = 12'd1890;
        default: cycles = 12'd3778;
      endcase
    end else begin
      case (idx)
        4'd0:    cycles = 12'd4;
        4'd1:    cycles = 12'd8;
        4'd2:    cycles = 12'd16;
        4'd3:    cycles = 12'd32;
        4'd4:    cycles = 12'd64;
        4'd5:    cycles = 12'd96;
        4'd6:    cycles = 12'd128;
        4'd7:    cycles = 12'd160;
        4'd8:    cycles = 12'd202;
        4'd9:    cycles = 12'd254;
        4'd10:   cycles = 12'd380;
        4'd11:   cycles = 12'd508;
        4'd12:   cycles = 12'd762;
        4'd13:   cycles = 12'd1016;
        4'd14:   cycles = 12'd2034;
        default: cycles = 12'd4068;
      endcase
    end
    return cycles;
  endfunction

  // Length counter load value for each 5-bit length index.
  function automatic logic [7:0] length_count(input logic [4:0] idx);
    logic [7:0] count;
    case (idx)
      5'd0:    count = 8'd10;
      5'd1:    count = 8'd254;
      5'd2:    count = 8'd20;
      5'd3:    count = 8'd2;
      5'd4:    count = 8'd40;
      5'd5:    count = 8'd4;
      5'd6:    count = 8'd80;
      5'd7:    count = 8'd6;
      5'd8:    count = 8'd160;
      5'd9:    count = 8'd8;
      5'd10:   count = 8'd60;
      5'd11:   count = 8'd10;
      5'd12:   count = 8'd14;
      5'd13:   count = 8'd12;
      5'd14:   count = 8'd26;
      5'd15:   count = 8'd14;
      5'd16:   count = 8'd12;
      5'd17:   count = 8'd16;
      5'd18:   count = 8'd24;
      5'd19:   count = 8'd18;
      5'd20:   count = 8'd48;
      5'd21:   count = 8'd20;
      5'd22:   count = 8'd96;
      5'd23:   count = 8'd22;
      5'd24:   count = 8'd192;
      5'd25:   count = 8'd24;
      5'd26:   count = 8'd72;
      5'd27:   count = 8'd26;
      5'd28:   count = 8'd16;
      5'd29:   count = 8'd28;
      5'd30:   count = 8'd32;
      default: count = 8'd30;
    endcase
    return count;
  endfunction

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic       we_ctrl;     // $400C
  logic       we_period;   // $400E
  logic       we_length;   // $400F

  assign we_ctrl   = reg_we && (reg_addr == 2'd0);
  assign we_period = reg_we && (reg_addr == 2'd2);
  assign we_length = reg_we && (reg_addr == 2'd3);

  logic       halt;        // H: length halt / envelope loop
  logic       const_vol;   // C: constant volume select
  logic [3:0] volume;      // V: constant volume or envelope divider period
  logic       mode;        // M: short-sequence LFSR tap
  logic [3:0] period_idx;  // P: timer period index

  // The length index is consumed on the $400F write itself (it only selects
  // the load value), so it never needs to be held in a register.
  // NOTE: synchronous reset lives inside the clocked block; every register
  // here is a discrete flop, so all of them are reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt       <= 1'b0;
      const_vol  <= 1'b0;
      volume     <= 4'd0;
      mode       <= 1'b0;
      period_idx <= 4'd0;
    end else begin
      if (we_ctrl) begin
        halt      <= reg_data[5];
        const_vol <= reg_data[4];
        volume    <= reg_data[3:0];
      end
      if (we_period) begin
        mode       <= reg_data[7];
        period_idx <= reg_data[3:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Period timer and LFSR
  // -------------------------------------------------------------------------
  logic [11:0] timer;
  logic [14:0] lfsr;
  logic [11:0] timer_reload;
  logic        feedback;

  // A write to $400E landing on a reload cycle is picked up at the following
  // reload, because period_idx only changes after this edge.
  assign timer_reload = period_cycles(period_idx) - 12'd1;
  assign feedback     = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);

  // NOTE: non-blocking assignments so every branch sees the pre-edge state,
  // regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 12'd0;
      lfsr  <= 15'h0001;
    end else if (cpu_en) begin
      if (timer == 12'd0) begin
        timer <= timer_reload;
        lfsr  <= {feedback, lfsr[14:1]};
      end else begin
        timer <= timer - 12'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Length counter
  // -------------------------------------------------------------------------
  logic [7:0] length_cnt;

  // A load wins over a coincident hframe; a disabled channel is forced to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      length_cnt <= 8'd0;
    end else if (we_length && enable) begin
      length_cnt <= length_count(reg_data[7:3]);
    end else if (!enable) begin
      length_cnt <= 8'd0;
    end else if (hframe && (length_cnt != 8'd0) && !halt) begin
      length_cnt <= length_cnt - 8'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Envelope
  // -------------------------------------------------------------------------
  logic       start_flag;
  logic [3:0] divider;
  logic [3:0] decay;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_flag <= 1'b0;
      divider    <= 4'd0;
      decay      <= 4'd0;
    end else begin
      if (qframe) begin
        if (start_flag) begin
          decay   <= 4'd15;
          divider <= volume;
        end else if (divider == 4'd0) begin
          divider <= volume;
          if (decay != 4'd0) begin
            decay <= decay - 4'd1;
          end else if (halt) begin
            decay <= 4'd15;
          end
        end else begin
          divider <= divider - 4'd1;
        end
      end

      // The qframe above acts on the old flag; a coincident $400F write
      // still leaves the flag set for the next quarter frame.
      if (we_length) begin
        start_flag <= 1'b1;
      end else if (qframe && start_flag) begin
        start_flag <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= 4'd0;
    end else if (lfsr[0] || (length_cnt == 8'd0)) begin
      out <= 4'd0;
    end else begin
      out <= const_vol ? volume : decay;
    end
  end

  // Gated with reset so the status bit is low for the whole reset window,
  // including the first cycle before the counter has been cleared.
  assign active = (length_cnt != 8'd0) && !reset;

endmodule
